// File: rtl/carry_resolve_unit.sv
// carry_resolve_unit
//   Resolves a half-adder Sum/Carry vector pair into a full WIDTH-bit sum by
//   iterating S <= S ^ (C<<1), C <= S & (C<<1) until no carries remain.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready is high only in IDLE; out_valid is high only in DONE.
//   Both are decoded from the registered state.
//   Optional feature macro: CARRY_RESOLVE_ITER_COUNT_EN. When it is defined,
//   iter_count reports the number of propagation iterations. When it is
//   undefined, iter_count is tied to 0.
module carry_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s_q, c_q;
  logic             cout_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;

  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] s_d, c_d;
  logic             cout_d;

  // One propagation step: shift the carries up, fold them into the sum,
  // and remember any carry shifted out of the top bit.
  always_comb begin
    sh_d   = {c_q[WIDTH-2:0], 1'b0};
    s_d    = s_q ^ sh_d;
    c_d    = s_q & sh_d;
    cout_d = cout_q | c_q[WIDTH-1];
  end

  // Control FSM with the datapath registers; results are latched on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cout_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q     <= in_sum;
            c_q     <= in_carry;
            cout_q  <= 1'b0;
            state_q <= ITER;
          end
        end
        ITER: begin
          if (c_q == '0) begin
            result_q    <= s_q;
            carry_out_q <= cout_q;
            state_q     <= DONE;
          end else begin
            s_q    <= s_d;
            c_q    <= c_d;
            cout_q <= cout_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CARRY_RESOLVE_ITER_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] iter_count_q;

  // Iteration counter; its value is published when the FSM enters DONE and
  // held until the next accepted pair clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      iter_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q        <= '0;
            iter_count_q <= '0;
          end
        end
        ITER: begin
          if (c_q == '0) begin
            iter_count_q <= cnt_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign iter_count = iter_count_q;
`else
  assign iter_count = '0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_carry_resolve_unit.sv
// Testbench for carry_resolve_unit: a table of directed vectors, hand-written
// hold and mid-operation reset sequences, and randomized half-adder pairs
// checked against plain integer addition.
module tb_carry_resolve_unit;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic [W-1:0]  in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry_out;
  logic [CW-1:0] iter_count;

  int checks;
  int failures;

  // Scoreboard queue: {carry_out, result} expected for each random pair.
  logic [W:0] exp_q[$];

  carry_resolve_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .iter_count (iter_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic [W-1:0] exp_r;
    logic        exp_co;
    int          exp_it;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Steps to the next sampling point, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pair, waits for the result, optionally stalls the consumer,
  // then completes the output handshake. Inputs are scrambled while busy.
  task automatic run_txn(input logic [W-1:0] s, input logic [W-1:0] c, input int stall,
                         output logic [W-1:0] r, output logic co, output logic [CW-1:0] it,
                         output int lat);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_sum    = s;
    in_carry  = c;
    out_ready = 1'b0;
    tick();
    lat = 1;
    chk("in_ready_busy", in_ready, 0);
    in_valid = 1'($urandom_range(0, 1));
    in_sum   = $urandom;
    in_carry = $urandom;
    while (!out_valid && lat < W + 10) begin
      tick();
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
    r  = result;
    co = carry_out;
    it = iter_count;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_result", result, r);
      chk("stall_cout", carry_out, co);
      chk("stall_iter", iter_count, it);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0]  r;
    logic          co;
    logic [CW-1:0] it;
    int            lat;
    logic [W-1:0]  a, b;
    logic [W:0]    full;
    logic [W:0]    exp_e;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;

    vecs[0] = '{"zero_carry",   32'h0000_00F0, 32'h0000_0000, 32'h0000_00F0, 1'b0, 0};
    vecs[1] = '{"one_plus_one", 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1};
    vecs[2] = '{"worst_case",   32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b1, 32};
    vecs[3] = '{"msb_overflow", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[4] = '{"three_five",   32'h0000_0006, 32'h0000_0001, 32'h0000_0008, 1'b0, 3};
    vecs[5] = '{"to_msb",       32'h7FFF_FFFE, 32'h0000_0001, 32'h8000_0000, 1'b0, 31};
    vecs[6] = '{"inconsist_lo", 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0, 1};
    vecs[7] = '{"inconsist_hi", 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1};

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_iter", iter_count, 0);
    rst = 1'b0;
    tick();

    // Directed table: result, overflow, iteration count and exact latency
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].sum, vecs[i].carry, 0, r, co, it, lat);
      chk({vecs[i].name, "_result"}, r, vecs[i].exp_r);
      chk({vecs[i].name, "_cout"}, co, vecs[i].exp_co);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_it + 2);
`ifdef CARRY_RESOLVE_ITER_COUNT_EN
      chk({vecs[i].name, "_iter"}, it, vecs[i].exp_it);
`else
      chk({vecs[i].name, "_iter"}, it, 0);
`endif
    end

    // Held output with out_ready low for 5 cycles
    run_txn(32'h0000_0000, 32'h8000_0000, 5, r, co, it, lat);
    chk("hold_result", r, 32'h0000_0000);
    chk("hold_cout", co, 1);

    // Reset in the middle of a worst-case operation
    in_valid = 1'b1;
    in_sum   = 32'hFFFF_FFFE;
    in_carry = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("midrst_busy", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_cout", carry_out, 0);
    chk("midrst_iter", iter_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("midrst_no_pulse", out_valid, 0);
    end
    run_txn(32'h0000_0006, 32'h0000_0001, 0, r, co, it, lat);
    chk("after_rst_result", r, 32'h0000_0008);
    chk("after_rst_cout", co, 0);

    // Random half-adder pairs against integer addition
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      if (n % 7 == 0) b = ~a + W'($urandom_range(0, 2));
      full = {1'b0, a} + {1'b0, b};
      exp_q.push_back(full);
      run_txn(a ^ b, a & b, $urandom_range(0, 3), r, co, it, lat);
      exp_e = exp_q.pop_front();
      chk("rand_result", r, exp_e[W-1:0]);
      chk("rand_cout", co, exp_e[W]);
      chk("rand_iter_max", (it <= CW'(W)), 1);
`ifdef CARRY_RESOLVE_ITER_COUNT_EN
      chk("rand_latency", lat, int'(it) + 2);
`else
      chk("rand_iter_zero", it, 0);
      chk("rand_latency_max", (lat <= W + 2), 1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carry_resolve_unit.md
Name: carry_resolve_unit

Overview:
- Downstream stage of the bitwise half-adder. It consumes the per-bit Sum (A^B) and Carry (A&B) vectors and iteratively propagates the carries into a full WIDTH-bit sum plus carry-out.
- Ripple resolution is done over multiple cycles using a small FSM and a valid/ready handshake on both sides.
- Result = in_sum + (in_carry << 1), modulo 2^WIDTH, with overflow reported on carry_out.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH+1), width of iter_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream has a Sum/Carry pair.
- in_ready  output  1  block can accept a pair.
- in_sum  input  WIDTH  half-adder Sum vector.
- in_carry  input  WIDTH  half-adder Carry vector (unshifted).
- out_valid  output  1  result is available.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  resolved sum.
- carry_out  output  1  sticky overflow out of bit WIDTH-1.
- iter_count  output  CNT_W  number of propagation iterations used (see Optional Feature).

Behaviour:
- Single clock domain; rst is sampled only at the rising edge of clk.
- Reset values: state=IDLE, S=0, C=0, result=0, carry_out=0, iter_count=0, out_valid=0, in_ready=1.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state.
- IDLE:
  - On in_valid && in_ready, load S<=in_sum, C<=in_carry, cout<=0, cnt<=0, then go to ITER.
  - Otherwise hold.
- ITER, one evaluation per cycle:
  - If C==0: go to DONE and drive result<=S. No update occurs in this cycle.
  - Else, with sh=C<<1 (bit WIDTH-1 of C dropped):
    - S<=S^sh
    - C<=S&sh
    - cout<=cout|C[WIDTH-1]
    - cnt<=cnt+1
    - stay in ITER.
- Termination: the lowest set bit of C rises by at least 1 per iteration, so n<=WIDTH iterations.
- Latency:
  - Accept edge E0; update edges E1..En; DONE is entered at E(n+1).
  - out_valid is high from E(n+1).
  - Minimum is 2 cycles (in_carry=0); maximum is WIDTH+2.
- DONE:
  - result, carry_out and iter_count are held stable while out_valid=1 && out_ready=0.
  - On out_ready, go to IDLE at that edge; out_valid=0 and in_ready=1 in the next cycle.
- No back-to-back accept: in_ready is 0 in ITER and DONE. in_valid/in_sum/in_carry are ignored outside IDLE.
- Arithmetic:
  - The invariant S+2C is preserved modulo 2^WIDTH, accounting for dropped carries.
  - carry_out is sticky-OR of all dropped bits.
  - For consistent inputs (in_sum & in_carry == 0), carry_out equals bit WIDTH of A+B.
  - For inconsistent inputs, result is still (in_sum + 2*in_carry) mod 2^WIDTH, and carry_out=1 if any overflow occurred.
- Reset mid-operation:
  - rst in ITER or DONE aborts the operation at that edge and returns all outputs to their reset values.
  - A pending result is discarded and no out_valid pulse follows.
- rst has priority over any handshake in the same cycle.

Optional Feature:
- Macro: CARRY_RESOLVE_ITER_COUNT_EN.
- Defined: iter_count = cnt latched on entry to DONE. It is held during DONE and the following IDLE, cleared on the next accept, and reset to 0.
- Undefined: the cnt register is not built and iter_count is tied to 0. All other behaviour and latency are unchanged.

Test Plan:
- Reset, then in_sum=0x0000_00F0, in_carry=0x0000_0000 -> result=0x0000_00F0, carry_out=0, out_valid 2 cycles after accept, iter_count=0.
- A=1,B=1 (in_sum=0, in_carry=1) -> result=0x0000_0002, carry_out=0, iter_count=1, out_valid 3 cycles after accept.
- A=0xFFFF_FFFF,B=1 (in_sum=0xFFFF_FFFE, in_carry=1) -> result=0, carry_out=1, iter_count=32, out_valid at cycle 34.
- A=0x8000_0000,B=0x8000_0000 (in_sum=0, in_carry=0x8000_0000) -> result=0, carry_out=1, iter_count=1. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; assert out_ready -> in_ready=1 next cycle.
- Start worst-case operand, assert rst at iteration 10 -> next cycle out_valid=0, result=0, in_ready=1. A new pair 3+5 -> result=8.
- Random 1000 A,B pairs from half-adder model with random out_ready stalls -> result=={A+B}[31:0], carry_out=={A+B}[32], iter_count<=32. Without the macro, iter_count==0 throughout.
